// File: rtl/buzzer_pkg.sv
// Shared encodings and pattern ROM for the buzzer sequencer.
package buzzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int PAT_W     = 8;
  localparam int NUM_BEATS = 8;

  localparam logic [PAT_W-1:0] PATTERN_ALARM  = 8'b1010_1010;
  localparam logic [PAT_W-1:0] PATTERN_LONG   = 8'b1111_0000;
  localparam logic [PAT_W-1:0] PATTERN_DOUBLE = 8'b1100_1100;
  localparam logic [PAT_W-1:0] PATTERN_CHIRP  = 8'b1000_0000;

  // Beats are played MSB first, so beat 0 is bit 7.
  function automatic logic beat_on(input logic [1:0] sel, input logic [2:0] idx);
    logic [PAT_W-1:0] bits;
    case (sel)
      2'd0:    bits = PATTERN_ALARM;
      2'd1:    bits = PATTERN_LONG;
      2'd2:    bits = PATTERN_DOUBLE;
      default: bits = PATTERN_CHIRP;
    endcase
    return bits[3'd7 - idx];
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave phase generator; phase is the value for the coming cycle so the
// caller can register it straight into the buzzer flop.
module tone_gen #(
  parameter int TONE_DIV = 12500
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic phase
);

  localparam int TW = $clog2(TONE_DIV + 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(TONE_DIV - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_d;

endmodule

// File: rtl/buzzer_player.sv
// Pattern-driven buzzer sequencer with play/busy/done handshake.
// Define BUZZER_TONE_EN for a passive piezo (square-wave tone on on-beats).
module buzzer_player
  import buzzer_pkg::*;
#(
  parameter int COUNT_MAX = 25000000,
  parameter int TONE_DIV  = 12500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic [1:0] pattern,
  input  logic       stop,
  output logic       buzzer,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  // Handshake: play is sampled only while busy=0 (IDLE) and is accepted on
  // that edge unless stop is also high; done pulses one cycle after the last
  // beat; stop aborts from any busy state with no done pulse.

  localparam int CW = $clog2(COUNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_MAX - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [2:0]    beat_idx_q, beat_idx_d;
  logic [1:0]    pat_q, pat_d;
  logic          buzzer_q, buzzer_d;
  logic          accept, last_cyc, tone_phase;

  assign accept   = (state_q == ST_IDLE) && play && !stop;
  assign last_cyc = (beat_cnt_q == CNT_LAST);

`ifdef BUZZER_TONE_EN
  logic tone_restart, tone_en;
  assign tone_en      = (state_q == ST_PLAY) && !stop;
  assign tone_restart = accept || (tone_en && last_cyc);

  tone_gen #(.TONE_DIV(TONE_DIV)) u_tone_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (tone_restart),
    .en      (tone_en),
    .phase   (tone_phase)
  );
`else
  // Active buzzer: on-beats are a steady high level.
  assign tone_phase = (TONE_DIV > 0);
`endif

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    beat_idx_d = beat_idx_q;
    pat_d      = pat_q;
    buzzer_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_PLAY;
          pat_d      = pattern;
          beat_cnt_d = '0;
          beat_idx_d = '0;
          buzzer_d   = beat_on(pattern, 3'd0) & tone_phase;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
          beat_idx_d = '0;
        end else if (last_cyc) begin
          beat_cnt_d = '0;
          if (beat_idx_q == 3'd7) begin
            state_d    = ST_DONE;
            beat_idx_d = '0;
          end else begin
            beat_idx_d = beat_idx_q + 3'd1;
            buzzer_d   = beat_on(pat_q, beat_idx_q + 3'd1) & tone_phase;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          buzzer_d   = beat_on(pat_q, beat_idx_q) & tone_phase;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
        beat_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      beat_idx_q <= '0;
      pat_q      <= '0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      beat_idx_q <= beat_idx_d;
      pat_q      <= pat_d;
      buzzer_q   <= buzzer_d;
    end
  end

  assign buzzer    = buzzer_q;
  assign busy      = (state_q == ST_PLAY) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule
